seq_shifter: RTL

- Parametrised multi-cycle shift unit for the ALU datapath.
- Generalises the single-bit SRL slice to an N-bit word with four modes: SLL, SRL, SRA and optional ROR.
- Shifts by at most STEP bits per clock and uses a start/done handshake.
- Sits beside the ALU and is launched by the control unit for shift instructions.

---
 rtl/seq_shifter_if.sv | 18 +
 rtl/seq_shifter.sv | 92 +++++++++
 2 files changed

// File: rtl/seq_shifter_if.sv
// Start/done handshake bundle for the multi-cycle shifter.
interface seq_shifter_if #(
  parameter int N = 32
);
  localparam int SW = $clog2(N);

  logic          start;
  logic [1:0]    op;
  logic [N-1:0]  a;
  logic [SW-1:0] shamt;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic          zero;

  modport master (output start, op, a, shamt, input busy, done, result, zero);
  modport slave  (input start, op, a, shamt, output busy, done, result, zero);
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA(/ROR) unit, at most STEP bit positions per clock.
// Define SEQ_SHIFTER_ROTATE_EN for rotate-right on op=11; otherwise op=11 is SRL.
module seq_shifter #(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_shifter_if.slave  bus
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  wr;
  logic [N-1:0]  res;
  logic [SW-1:0] rem;
  logic [1:0]    opr;
  logic          busy_q;
  logic          done_q;
  logic [SW-1:0] k;
  logic [N-1:0]  wr_sh;

  // rem never exceeds N-1, so k always fits in SW bits even when STEP==N
  always_comb begin
    k = rem;
    if (int'(rem) >= STEP) k = SW'(STEP);
  end

  always_comb begin
    wr_sh = wr >> k;
    case (opr)
      2'b00:   wr_sh = wr << k;
      2'b10:   wr_sh = $signed(wr) >>> k;
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11:   wr_sh = (wr >> k) | (wr << (N - int'(k)));
`endif
      default: wr_sh = wr >> k;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr     <= '0;
      res    <= '0;
      rem    <= '0;
      opr    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            res    <= wr;
            done_q <= 1'b1;
          end
          // DONE accepts a new request just like IDLE, giving back-to-back issue
          if (bus.start) begin
            wr     <= bus.a;
            rem    <= bus.shamt;
            opr    <= bus.op;
            state  <= (bus.shamt != '0) ? SHIFT : DONE;
            busy_q <= (bus.shamt != '0);
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          wr  <= wr_sh;
          rem <= rem - k;
          if (rem == k) begin
            state  <= DONE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res;
  assign bus.zero   = (res == '0);
endmodule
